// File: rtl/axis_bram_reader_sequencer.sv
// Replays a one-shot AXI-Stream BRAM reader a programmed number of times by pulsing
// its reset between bursts, with a programmable idle gap and abort.
module axis_bram_reader_sequencer #(
    parameter int unsigned BRAM_ADDR_WIDTH = 10,
    parameter int unsigned CNTR_WIDTH      = 32
) (
    input  logic                       i_aclk,
    input  logic                       i_aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_cfg_last,
    input  logic [CNTR_WIDTH-1:0]      i_cfg_bursts,
    input  logic [CNTR_WIDTH-1:0]      i_cfg_gap,
    input  logic                       i_trg_start,
    input  logic                       i_ctl_abort,
    input  logic                       i_mon_tvalid,
    input  logic                       i_mon_tready,
    input  logic                       i_mon_tlast,
    output logic                       o_reader_aresetn,
    output logic [BRAM_ADDR_WIDTH-1:0] o_reader_cfg_data,
    output logic [CNTR_WIDTH-1:0]      o_sts_bursts,
    output logic                       o_sts_busy
);

    typedef enum logic [1:0] {StIdle, StHold, StRun} state_t;

    state_t                     r_state, w_state_next;
    logic [CNTR_WIDTH-1:0]      r_gap_cnt, w_gap_cnt_next;
    logic [CNTR_WIDTH-1:0]      r_shadow, w_shadow_next;
    logic [CNTR_WIDTH-1:0]      r_sts_bursts, w_sts_bursts_next;
    logic [BRAM_ADDR_WIDTH-1:0] r_cfg_data, w_cfg_data_next;
    logic                       r_reader_aresetn, w_reader_aresetn_next;
    logic                       r_busy, w_busy_next;
    logic                       w_eot;
    logic [CNTR_WIDTH-1:0]      w_bursts_inc;

    assign w_eot        = i_mon_tvalid & i_mon_tready & i_mon_tlast;
    assign w_bursts_inc = r_sts_bursts + CNTR_WIDTH'(1);

    always_comb begin
        w_state_next          = r_state;
        w_gap_cnt_next        = r_gap_cnt;
        w_shadow_next         = r_shadow;
        w_sts_bursts_next     = r_sts_bursts;
        w_cfg_data_next       = r_cfg_data;
        w_reader_aresetn_next = r_reader_aresetn;
        w_busy_next           = r_busy;

        unique case (r_state)
            StIdle: begin
                w_reader_aresetn_next = 1'b0;
                w_busy_next           = 1'b0;
                if (i_trg_start && (i_cfg_bursts != '0) && !i_ctl_abort) begin
                    w_cfg_data_next   = i_cfg_last;
                    w_shadow_next     = i_cfg_bursts;
                    w_gap_cnt_next    = '0;
                    w_sts_bursts_next = '0;
                    w_busy_next       = 1'b1;
                    w_state_next      = StHold;
                end
            end
            StHold: begin
                if (r_gap_cnt == '0) begin
                    w_reader_aresetn_next = 1'b1;
                    w_state_next          = StRun;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - CNTR_WIDTH'(1);
                end
            end
            StRun: begin
                // Reset the reader only after tlast so its output pipeline is already drained.
                if (w_eot) begin
                    w_sts_bursts_next     = w_bursts_inc;
                    w_reader_aresetn_next = 1'b0;
                    if (w_bursts_inc == r_shadow) begin
                        w_busy_next  = 1'b0;
                        w_state_next = StIdle;
                    end else begin
                        w_gap_cnt_next = i_cfg_gap;
                        w_state_next   = StHold;
                    end
                end
            end
            default: begin
                w_reader_aresetn_next = 1'b0;
                w_busy_next           = 1'b0;
                w_state_next          = StIdle;
            end
        endcase

        if (i_ctl_abort) begin
            w_state_next          = StIdle;
            w_reader_aresetn_next = 1'b0;
            w_busy_next           = 1'b0;
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state          <= StIdle;
            r_gap_cnt        <= '0;
            r_shadow         <= '0;
            r_sts_bursts     <= '0;
            r_cfg_data       <= '0;
            r_reader_aresetn <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_gap_cnt        <= w_gap_cnt_next;
            r_shadow         <= w_shadow_next;
            r_sts_bursts     <= w_sts_bursts_next;
            r_cfg_data       <= w_cfg_data_next;
            r_reader_aresetn <= w_reader_aresetn_next;
            r_busy           <= w_busy_next;
        end
    end

    assign o_reader_aresetn  = r_reader_aresetn;
    assign o_reader_cfg_data = r_cfg_data;
    assign o_sts_bursts      = r_sts_bursts;
    assign o_sts_busy        = r_busy;

endmodule

// File: tb/tb_axis_bram_reader_sequencer.sv
// Bench: a behavioural one-shot BRAM reader feeds the sequencer; runs are checked against
// expected word streams, burst counts and reader-reset low times.
module tb_axis_bram_reader_sequencer;

    localparam int AW = 10;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cfg_last;
    logic [CW-1:0] cfg_bursts, cfg_gap;
    logic          trg, abort_req;
    logic          mon_tvalid, mon_tready, mon_tlast;
    logic          rd_rstn, busy;
    logic [AW-1:0] cfg_data;
    logic [CW-1:0] sts_bursts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_bram_reader_sequencer #(
        .BRAM_ADDR_WIDTH (AW),
        .CNTR_WIDTH      (CW)
    ) dut (
        .i_aclk            (clk),
        .i_aresetn         (rst_n),
        .i_cfg_last        (cfg_last),
        .i_cfg_bursts      (cfg_bursts),
        .i_cfg_gap         (cfg_gap),
        .i_trg_start       (trg),
        .i_ctl_abort       (abort_req),
        .i_mon_tvalid      (mon_tvalid),
        .i_mon_tready      (mon_tready),
        .i_mon_tlast       (mon_tlast),
        .o_reader_aresetn  (rd_rstn),
        .o_reader_cfg_data (cfg_data),
        .o_sts_bursts      (sts_bursts),
        .o_sts_busy        (busy)
    );

    // One-shot reader: streams mem[0..cfg_data] once after reset release, then stops.
    logic [15:0]   rd_mem [0:1023];
    logic [AW-1:0] rd_addr = '0;
    logic          rd_done = 1'b1;

    assign mon_tvalid = rd_rstn && !rd_done;
    assign mon_tlast  = (rd_addr == cfg_data);

    always @(posedge clk) begin
        if (!rd_rstn) begin
            rd_addr <= '0;
            rd_done <= 1'b0;
        end else if (mon_tvalid && mon_tready) begin
            if (mon_tlast) rd_done <= 1'b1;
            else           rd_addr <= rd_addr + 1'b1;
        end
    end

    logic [15:0] words[$];
    int          lows[$];
    int          eot_cnt = 0;
    int          lowcnt  = 0;

    always @(posedge clk) begin
        if (mon_tvalid && mon_tready) begin
            words.push_back(rd_mem[rd_addr]);
            if (mon_tlast) eot_cnt++;
        end
        if (!busy) lowcnt = 0;
        else if (!rd_rstn) lowcnt++;
        else if (lowcnt > 0) begin
            lows.push_back(lowcnt);
            lowcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        words.delete();
        lows.delete();
        eot_cnt = 0;
    endtask

    task automatic pulse_start(input int last, input int bursts, input int gap);
        @(negedge clk);
        cfg_last   = AW'(last);
        cfg_bursts = CW'(bursts);
        cfg_gap    = CW'(gap);
        trg        = 1'b1;
        @(negedge clk);
        trg = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit rnd_ready);
        int budget = 0;
        while (busy && budget < 20000) begin
            if (rnd_ready) mon_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget++;
        end
        mon_tready = 1'b1;
        chk(tag, busy, 0);
    endtask

    task automatic do_run(input int last, input int bursts, input int gap, input bit rnd_ready);
        int len = last + 1;
        int bad;
        clear_mon();
        pulse_start(last, bursts, gap);
        chk("start_busy", busy, 1);
        chk("start_rst_low", rd_rstn, 0);
        chk("cfg_data_latched", cfg_data, last);
        @(negedge clk);
        chk("rst_rise_e1", rd_rstn, 1);
        // Mid-run edits of the end address must not reach the reader.
        cfg_last = AW'($urandom_range(0, 1023));
        wait_idle("run_timeout", rnd_ready);
        chk("sts_bursts", sts_bursts, bursts);
        chk("eot_cnt", eot_cnt, bursts);
        chk("rst_low_after", rd_rstn, 0);
        chk("cfg_data_hold", cfg_data, last);
        chk("word_cnt", words.size(), bursts * len);
        bad = 0;
        foreach (words[i]) if (words[i] !== rd_mem[i % len]) bad++;
        chk("word_data", bad, 0);
        chk("low_runs", lows.size(), bursts);
        bad = 0;
        foreach (lows[i]) if (lows[i] != ((i == 0) ? 1 : gap + 1)) bad++;
        chk("low_lengths", bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        for (int i = 0; i < 1024; i++) rd_mem[i] = 16'($urandom);
        rst_n      = 1'b0;
        cfg_last   = '0;
        cfg_bursts = '0;
        cfg_gap    = '0;
        trg        = 1'b0;
        abort_req  = 1'b0;
        mon_tready = 1'b1;
        #1;
        chk("por_rstn", rd_rstn, 0);
        chk("por_busy", busy, 0);
        chk("por_sts", sts_bursts, 0);
        chk("por_cfg", cfg_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a run.
        clear_mon();
        pulse_start(7, 3, 0);
        repeat (6) @(negedge clk);
        chk("mid_run_active", rd_rstn, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rstn", rd_rstn, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sts", sts_bursts, 0);
        chk("arst_cfg", cfg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_arst_busy", busy, 0);
        chk("post_arst_rstn", rd_rstn, 0);

        do_run(7, 3, 0, 1'b0);
        do_run(7, 2, 5, 1'b0);
        do_run(5, 4, 2, 1'b1);
        do_run(0, 3, 1, 1'b1);
        for (int r = 0; r < 3; r++)
            do_run($urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(0, 4), 1'b1);

        // Abort mid-burst 2 of 5.
        clear_mon();
        pulse_start(7, 5, 0);
        budget = 0;
        while (words.size() < 11 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        chk("abort_reach", words.size(), 11);
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rstn", rd_rstn, 0);
        chk("abort_sts", sts_bursts, 1);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", busy, 0);

        // Abort landing on the same edge as the second tlast.
        clear_mon();
        pulse_start(7, 5, 0);
        budget = 0;
        while (!(eot_cnt == 1 && mon_tvalid && mon_tlast) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        chk("abort_eot_reach", eot_cnt, 1);
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        chk("abort_eot_sts", sts_bursts, 2);
        chk("abort_eot_busy", busy, 0);
        chk("abort_eot_rstn", rd_rstn, 0);

        // Zero-burst start request is refused.
        @(negedge clk);
        cfg_last   = AW'(3);
        cfg_bursts = '0;
        trg        = 1'b1;
        repeat (3) @(negedge clk);
        trg = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_rstn", rd_rstn, 0);
        chk("zero_sts", sts_bursts, 2);
        chk("zero_cfg", cfg_data, 7);

        // Start held high: one run completes, then a fresh run begins.
        clear_mon();
        cfg_last   = AW'(3);
        cfg_bursts = CW'(2);
        cfg_gap    = CW'(1);
        trg        = 1'b1;
        @(negedge clk);
        chk("held_busy", busy, 1);
        budget = 0;
        while (busy && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        chk("held_end_busy", busy, 0);
        chk("held_end_sts", sts_bursts, 2);
        chk("held_end_eot", eot_cnt, 2);
        @(negedge clk);
        chk("held_restart_busy", busy, 1);
        chk("held_restart_sts", sts_bursts, 0);
        trg = 1'b0;
        wait_idle("held_second_timeout", 1'b0);
        chk("held_second_sts", sts_bursts, 2);
        chk("held_total_eot", eot_cnt, 4);
        chk("held_total_words", words.size(), 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
